ex_muldiv: RTL and testbench

//   Iterative RV32M multiply/divide unit beside the single-cycle Execute stage.

---
 rtl/ex_muldiv_pkg.sv | 53 +++++
 rtl/ex_muldiv_md_step.sv | 41 ++++
 rtl/ex_muldiv.sv | 179 +++++++++++++++++
 tb/tb_ex_muldiv.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit:
// funct3 codes, instruction IDs, FSM states and the latched control bundle.
package ex_muldiv_pkg;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [2:0] {
        ID_MUL    = MD_MUL,
        ID_MULH   = MD_MULH,
        ID_MULHSU = MD_MULHSU,
        ID_MULHU  = MD_MULHU,
        ID_DIV    = MD_DIV,
        ID_DIVU   = MD_DIVU,
        ID_REM    = MD_REM,
        ID_REMU   = MD_REMU
    } md_id_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } md_state_e;

    typedef struct packed {
        md_id_e     id;
        logic [4:0] rd;
        logic       neg_a;
        logic       neg_b;
    } md_ctl_t;

    // Bit 2 of funct3 separates the divide group from the multiply group.
    function automatic logic is_div(input md_id_e id);
        return id[2];
    endfunction

    function automatic logic rs1_signed(input md_id_e id);
        return id == ID_MULH || id == ID_MULHSU ||
               id == ID_DIV || id == ID_REM;
    endfunction

    function automatic logic rs2_signed(input md_id_e id);
        return id == ID_MULH || id == ID_DIV || id == ID_REM;
    endfunction

endpackage

// File: rtl/ex_muldiv_md_step.sv
// One combinational radix-2 step on the {acc,q} register pair.
// Ports: div (mode: 0 shift-add multiply, 1 restoring divide),
//   b (multiplicand/divisor magnitude), acc_i/q_i in, acc_o/q_o out.
module md_step #(
    parameter int XLEN = 32
) (
    input  logic            div,
    input  logic [XLEN-1:0] b,
    input  logic [XLEN-1:0] acc_i,
    input  logic [XLEN-1:0] q_i,
    output logic [XLEN-1:0] acc_o,
    output logic [XLEN-1:0] q_o
);

    logic [XLEN:0] sum;
    logic [XLEN:0] rem;
    logic [XLEN:0] diff;

    always_comb begin
        // Multiply: add b when the LSB of the multiplier is set,
        // then shift {carry,acc,q} right by one.
        sum  = {1'b0, acc_i} + {1'b0, b & {XLEN{q_i[0]}}};
        // Divide: shift {acc,q} left, trial-subtract b. The partial
        // remainder is always < b, so bit XLEN of diff is the borrow.
        rem  = {acc_i, q_i[XLEN-1]};
        diff = rem - {1'b0, b};
        if (div) begin
            if (!diff[XLEN]) begin
                acc_o = diff[XLEN-1:0];
                q_o   = {q_i[XLEN-2:0], 1'b1};
            end else begin
                acc_o = rem[XLEN-1:0];
                q_o   = {q_i[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_o = sum[XLEN:1];
            q_o   = {sum[0], q_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit beside the Execute stage.
// Ports: clk, rst_n (async, active low), flush; in_vld/in_rdy with
//   in_op (funct3), in_rd, in_x_rs1, in_x_rs2; out_vld/out_rdy with
//   out_rd, out_x_rd; busy is high whenever the unit is not idle.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_vld,
    output logic            in_rdy,
    input  logic [2:0]      in_op,
    input  logic [4:0]      in_rd,
    input  logic [XLEN-1:0] in_x_rs1,
    input  logic [XLEN-1:0] in_x_rs2,
    output logic            out_vld,
    input  logic            out_rdy,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_x_rd,
    output logic            busy
);

    localparam int STEPS = XLEN / UNROLL;
    localparam int CNT_W = $clog2(STEPS);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(STEPS - 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e        state_q;
    md_state_e        state_n;
    logic [CNT_W-1:0] cnt_q;
    md_ctl_t          ctl_q;
    logic [XLEN-1:0]  b_q;
    logic [XLEN-1:0]  acc_q;
    logic [XLEN-1:0]  q_q;
    logic             out_vld_q;
    logic [4:0]       out_rd_q;
    logic [XLEN-1:0]  out_x_q;

    md_id_e          id_in;
    logic            sgn_a;
    logic            sgn_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic            accept;

    assign in_rdy   = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign accept   = in_vld && in_rdy && !flush;
    assign out_vld  = out_vld_q;
    assign out_rd   = out_rd_q;
    assign out_x_rd = out_x_q;

    always_comb begin
        id_in    = md_id_e'(in_op);
        sgn_a    = rs1_signed(id_in) && in_x_rs1[XLEN-1];
        sgn_b    = rs2_signed(id_in) && in_x_rs2[XLEN-1];
        mag_a    = sgn_a ? -in_x_rs1 : in_x_rs1;
        mag_b    = sgn_b ? -in_x_rs2 : in_x_rs2;
        div_zero = is_div(id_in) && (in_x_rs2 == '0);
        div_ovf  = (id_in == ID_DIV || id_in == ID_REM) &&
                   (in_x_rs1 == INT_MIN) && (in_x_rs2 == '1);
        special  = div_zero || div_ovf;
    end

    logic [XLEN-1:0] acc_c [UNROLL+1];
    logic [XLEN-1:0] q_c   [UNROLL+1];

    assign acc_c[0] = acc_q;
    assign q_c[0]   = q_q;

    for (genvar i = 0; i < UNROLL; i++) begin : g_step
        md_step #(
            .XLEN (XLEN)
        ) u_step (
            .div   (is_div(ctl_q.id)),
            .b     (b_q),
            .acc_i (acc_c[i]),
            .q_i   (q_c[i]),
            .acc_o (acc_c[i+1]),
            .q_o   (q_c[i+1])
        );
    end

    logic              flip;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   res;

    // After CALC: mul leaves the product in {acc,q};
    // div leaves quotient in q and remainder in acc.
    always_comb begin
        flip = ctl_q.neg_a ^ ctl_q.neg_b;
        prod = flip ? -{acc_q, q_q} : {acc_q, q_q};
        quo  = flip ? -q_q : q_q;
        rem  = ctl_q.neg_a ? -acc_q : acc_q;
        res  = '0;
        unique case (1'b1)
            !ctl_q.id[2] && ctl_q.id == ID_MUL:
                res = prod[XLEN-1:0];
            !ctl_q.id[2] && ctl_q.id != ID_MUL:
                res = prod[2*XLEN-1:XLEN];
            ctl_q.id[2] && !ctl_q.id[1]:
                res = quo;
            ctl_q.id[2] && ctl_q.id[1]:
                res = rem;
            default:
                res = '0;
        endcase
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_n = special ? ST_FIXUP : ST_CALC;
            ST_CALC:  if (cnt_q == '0) state_n = ST_FIXUP;
            ST_FIXUP: state_n = ST_DONE;
            ST_DONE:  if (out_rdy) state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
        if (flush) state_n = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ctl_q     <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            out_vld_q <= 1'b0;
            out_rd_q  <= '0;
            out_x_q   <= '0;
        end else begin
            state_q   <= state_n;
            out_vld_q <= (state_n == ST_DONE);
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        // Special divides are resolved here: results are
                        // preloaded raw and sign correction is disabled.
                        ctl_q.id    <= id_in;
                        ctl_q.rd    <= in_rd;
                        ctl_q.neg_a <= sgn_a && !special;
                        ctl_q.neg_b <= sgn_b && !special;
                        b_q         <= mag_b;
                        cnt_q       <= CNT_INIT;
                        if (special) begin
                            acc_q <= div_zero ? in_x_rs1 : '0;
                            q_q   <= div_zero ? '1 : in_x_rs1;
                        end else begin
                            acc_q <= '0;
                            q_q   <= mag_a;
                        end
                    end
                end
                ST_CALC: begin
                    acc_q <= acc_c[UNROLL];
                    q_q   <= q_c[UNROLL];
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                ST_FIXUP: begin
                    out_x_q  <= res;
                    out_rd_q <= ctl_q.rd;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: UNROLL=1 and UNROLL=4 instances,
// scoreboard of expected results, directed and reference-model ops.
module tb_ex_muldiv;

    localparam int XLEN = 32;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_vld;
    logic        out_rdy;
    logic [2:0]  in_op;
    logic [4:0]  in_rd;
    logic [31:0] in_x_rs1;
    logic [31:0] in_x_rs2;
    logic        sel;

    logic        in_rdy1, out_vld1, busy1;
    logic [4:0]  out_rd1;
    logic [31:0] out_x1;
    logic        in_rdy4, out_vld4, busy4;
    logic [4:0]  out_rd4;
    logic [31:0] out_x4;

    logic        in_rdy, out_vld, busy;
    logic [4:0]  out_rd;
    logic [31:0] out_x_rd;

    assign in_rdy   = sel ? in_rdy4  : in_rdy1;
    assign out_vld  = sel ? out_vld4 : out_vld1;
    assign busy     = sel ? busy4    : busy1;
    assign out_rd   = sel ? out_rd4  : out_rd1;
    assign out_x_rd = sel ? out_x4   : out_x1;

    ex_muldiv #(.XLEN(XLEN), .UNROLL(1)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_vld   (in_vld && !sel),
        .in_rdy   (in_rdy1),
        .in_op    (in_op),
        .in_rd    (in_rd),
        .in_x_rs1 (in_x_rs1),
        .in_x_rs2 (in_x_rs2),
        .out_vld  (out_vld1),
        .out_rdy  (out_rdy && !sel),
        .out_rd   (out_rd1),
        .out_x_rd (out_x1),
        .busy     (busy1)
    );

    ex_muldiv #(.XLEN(XLEN), .UNROLL(4)) u_dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_vld   (in_vld && sel),
        .in_rdy   (in_rdy4),
        .in_op    (in_op),
        .in_rd    (in_rd),
        .in_x_rs1 (in_x_rs1),
        .in_x_rs2 (in_x_rs2),
        .out_vld  (out_vld4),
        .out_rdy  (out_rdy && sel),
        .out_rd   (out_rd4),
        .out_x_rd (out_x4),
        .busy     (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] x;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_md(input logic [2:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        longint          sa, sb2;
        longint unsigned ua, ub;
        logic [63:0]     p;
        logic [31:0]     r;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        p   = '0;
        r   = '0;
        case (op)
            3'd0: begin p = ua * ub; r = p[31:0]; end
            3'd1: begin p = sa * sb2; r = p[63:32]; end
            3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = '1;
                else begin p = sa / sb2; r = p[31:0]; end
            end
            3'd5: begin
                if (b == 0) r = '1;
                else begin p = ua / ub; r = p[31:0]; end
            end
            3'd6: begin
                if (b == 0) r = a;
                else begin p = sa % sb2; r = p[31:0]; end
            end
            default: begin
                if (b == 0) r = a;
                else begin p = ua % ub; r = p[31:0]; end
            end
        endcase
        return r;
    endfunction

    function automatic int lat_of(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic s);
        logic spc;
        spc = op[2] && (b == 0 || ((op == 3'd4 || op == 3'd6) &&
              a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        if (spc) return 2;
        return (s ? 8 : 32) + 2;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        exp_t e;
        check("in_rdy_idle", in_rdy, 1);
        in_op    = op;
        in_rd    = rd;
        in_x_rs1 = a;
        in_x_rs2 = b;
        in_vld   = 1'b1;
        tick();
        in_vld   = 1'b0;
        e.rd = rd;
        e.x  = exp;
        sb.push_back(e);
    endtask

    task automatic collect(input string tag, input int lat, input int hold);
        int   cyc;
        exp_t e;
        cyc = 1;
        while (!out_vld && cyc < 200) begin
            tick();
            cyc++;
        end
        check({tag, "_vld"}, out_vld, 1);
        check({tag, "_lat"}, cyc, lat);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            check({tag, "_x"}, out_x_rd, e.x);
            check({tag, "_rd"}, out_rd, e.rd);
            for (int i = 0; i < hold; i++) begin
                tick();
                check({tag, "_hold_vld"}, out_vld, 1);
                check({tag, "_hold_x"}, out_x_rd, e.x);
                check({tag, "_hold_rdy"}, in_rdy, 0);
            end
        end
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        check({tag, "_post_vld"}, out_vld, 0);
        check({tag, "_post_busy"}, busy, 0);
    endtask

    task automatic run(input string tag, input logic [2:0] op,
                       input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp,
                       input int hold);
        issue(op, rd, a, b, exp);
        collect(tag, lat_of(op, a, b, sel), hold);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  rop;
        int          cyc;
        exp_t        e;

        rst_n    = 1'b0;
        flush    = 1'b0;
        in_vld   = 1'b0;
        out_rdy  = 1'b0;
        in_op    = '0;
        in_rd    = '0;
        in_x_rs1 = '0;
        in_x_rs2 = '0;
        sel      = 1'b0;
        tick();
        tick();
        check("rst_vld1", out_vld1, 0);
        check("rst_busy1", busy1, 0);
        check("rst_x1", out_x1, 0);
        check("rst_rd1", out_rd1, 0);
        check("rst_rdy1", in_rdy1, 1);
        check("rst_vld4", out_vld4, 0);
        check("rst_x4", out_x4, 0);
        rst_n = 1'b1;
        tick();

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            run("mul", 3'd0, 5'd5, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
            run("mulh", 3'd1, 5'd6, 32'h8000_0000, 32'h8000_0000,
                32'h4000_0000, 0);
            run("mulhsu", 3'd2, 5'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                32'hFFFF_FFFF, 0);
            run("mulhu", 3'd3, 5'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                32'hFFFF_FFFE, 0);
            run("div", 3'd4, 5'd9, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
            run("rem", 3'd6, 5'd10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
            run("divu", 3'd5, 5'd11, 32'hFFFF_FFFF, 32'd16,
                32'h0FFF_FFFF, 0);
            run("remu", 3'd7, 5'd12, 32'hFFFF_FFFF, 32'd16, 32'hF, 0);
            run("div_z", 3'd4, 5'd13, 32'h1234_5678, 32'd0,
                32'hFFFF_FFFF, 0);
            run("rem_z", 3'd6, 5'd14, 32'h1234_5678, 32'd0,
                32'h1234_5678, 0);
            run("divu_z", 3'd5, 5'd15, 32'h8765_4321, 32'd0,
                32'hFFFF_FFFF, 0);
            run("remu_z", 3'd7, 5'd16, 32'h8765_4321, 32'd0,
                32'h8765_4321, 0);
            run("div_ovf", 3'd4, 5'd17, 32'h8000_0000, 32'hFFFF_FFFF,
                32'h8000_0000, 0);
            run("rem_ovf", 3'd6, 5'd18, 32'h8000_0000, 32'hFFFF_FFFF,
                32'd0, 0);
            for (int k = 0; k < 10; k++) begin
                rop = 3'($urandom_range(0, 7));
                case ($urandom_range(0, 3))
                    0: ra = 32'h8000_0000;
                    1: ra = 32'($urandom_range(0, 100));
                    default: ra = $urandom;
                endcase
                case ($urandom_range(0, 4))
                    0: rb = 32'hFFFF_FFFF;
                    1: rb = 32'($urandom_range(1, 9));
                    default: rb = $urandom;
                endcase
                run("rand", rop, 5'(k), ra, rb, ref_md(rop, ra, rb), 0);
            end
        end

        sel = 1'b0;

        // Flush during the tenth CALC cycle.
        in_op    = 3'd4;
        in_rd    = 5'd20;
        in_x_rs1 = 32'd100;
        in_x_rs2 = 32'd7;
        in_vld   = 1'b1;
        tick();
        in_vld = 1'b0;
        repeat (9) tick();
        check("flush_pre_busy", busy, 1);
        check("flush_pre_vld", out_vld, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_vld", out_vld, 0);
        check("flush_rdy", in_rdy, 1);
        run("after_flush", 3'd4, 5'd21, 32'd100, 32'd7, 32'd14, 0);

        // Flush and in_vld together: nothing accepted.
        in_op    = 3'd0;
        in_x_rs1 = 32'd3;
        in_x_rs2 = 32'd4;
        in_vld   = 1'b1;
        flush    = 1'b1;
        tick();
        in_vld = 1'b0;
        flush  = 1'b0;
        check("flush_vs_vld_busy", busy, 0);
        repeat (3) tick();
        check("flush_vs_vld_out", out_vld, 0);

        // Flush in DONE with out_rdy high: result dropped.
        issue(3'd0, 5'd22, 32'd3, 32'd4, 32'd12);
        cyc = 1;
        while (!out_vld && cyc < 200) begin
            tick();
            cyc++;
        end
        check("fdone_vld", out_vld, 1);
        flush   = 1'b1;
        out_rdy = 1'b1;
        tick();
        flush   = 1'b0;
        out_rdy = 1'b0;
        check("fdone_out_vld", out_vld, 0);
        check("fdone_busy", busy, 0);
        if (sb.size() != 0) e = sb.pop_front();

        // Back-pressure in DONE.
        run("hold", 3'd3, 5'd23, 32'h0001_0000, 32'h0003_0000, 32'd3, 5);

        // Asynchronous reset mid-CALC.
        issue(3'd5, 5'd24, 32'd1000, 32'd3, 32'd333);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("arst_vld", out_vld, 0);
        check("arst_busy", busy, 0);
        check("arst_x", out_x_rd, 0);
        check("arst_rd", out_rd, 0);
        check("arst_rdy", in_rdy, 1);
        if (sb.size() != 0) e = sb.pop_front();
        tick();
        rst_n = 1'b1;
        repeat (40) tick();
        check("arst_no_vld", out_vld, 0);
        run("after_rst", 3'd5, 5'd25, 32'd1000, 32'd3, 32'd333, 0);

        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
